// File: rtl/hvac_pkg.sv
// Shared plant-control types for the HVAC zone scheduler and related zone blocks.
package hvac_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LOCK} state_t;
  typedef enum logic {MODE_HEAT, MODE_COOL} mode_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first valid index strictly after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // ptr_i itself is visited last, so the most recent winner has lowest priority.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!found_o && valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/hvac_zone_scheduler.sv
// Round-robin sharing of one heat/cool plant among thermal zones, with minimum on-time,
// preemption quantum and a fixed off-time lockout between grants.
module hvac_zone_scheduler
  import hvac_pkg::*;
#(
  parameter int N_ZONES     = 4,
  parameter int MIN_RUN_CYC = 16,
  parameter int MAX_RUN_CYC = 64,
  parameter int LOCKOUT_CYC = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_ZONES-1:0]         heat_req,
  input  logic [N_ZONES-1:0]         cool_req,
  output logic                       heat,
  output logic                       cool,
  output logic                       idle,
  output logic                       lockout,
  output logic [N_ZONES-1:0]         zone_grant,
  output logic [$clog2(N_ZONES)-1:0] grant_id,
  output state_t                     dbg_state_o
);

  localparam int IW    = $clog2(N_ZONES);
  localparam int CNT_W = $clog2(max_int(MAX_RUN_CYC, LOCKOUT_CYC) + 1);
  localparam logic [CNT_W-1:0] RUN_MIN_LAST = CNT_W'(MIN_RUN_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_SAT      = CNT_W'(MAX_RUN_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCKOUT_CYC - 1);
  localparam logic [N_ZONES-1:0] ONE_HOT0   = {{(N_ZONES-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              heat_q, heat_d;
  logic              cool_q, cool_d;
  logic              idle_q, idle_d;
  logic              lockout_q, lockout_d;
  logic [N_ZONES-1:0] grant_q, grant_d;

  logic [N_ZONES-1:0] valid;
  logic [N_ZONES-1:0] gmask;
  logic               still_req;
  logic               drop;
  logic               other;
  logic               run_exit;
  logic               pick_found;
  logic [IW-1:0]      pick_idx;

  // A zone asking for both modes at once is treated as not asking at all.
  assign valid     = heat_req ^ cool_req;
  assign gmask     = ONE_HOT0 << gid_q;
  assign still_req = (mode_q == MODE_HEAT) ? (heat_req[gid_q] & ~cool_req[gid_q])
                                           : (cool_req[gid_q] & ~heat_req[gid_q]);
  assign drop      = ~still_req;
  assign other     = |(valid & ~gmask);
  assign run_exit  = ((cnt_q >= RUN_MIN_LAST) & drop) | ((cnt_q >= RUN_SAT) & other);

  rr_arbiter #(.N(N_ZONES), .IW(IW)) u_arb (
    .valid_i (valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_HEAT;
      cnt_q     <= '0;
      gid_q     <= '0;
      ptr_q     <= IW'(N_ZONES - 1);
      heat_q    <= 1'b0;
      cool_q    <= 1'b0;
      idle_q    <= 1'b1;
      lockout_q <= 1'b0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      gid_q     <= gid_d;
      ptr_q     <= ptr_d;
      heat_q    <= heat_d;
      cool_q    <= cool_d;
      idle_q    <= idle_d;
      lockout_q <= lockout_d;
      grant_q   <= grant_d;
    end
  end

  // One counter serves both the on-time (saturating) and the lockout countdown.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          gid_d   = pick_idx;
          ptr_d   = pick_idx;
          mode_d  = heat_req[pick_idx] ? MODE_HEAT : MODE_COOL;
        end
      end
      ST_RUN: begin
        if (run_exit) begin
          state_d = ST_LOCK;
          cnt_d   = '0;
        end else if (cnt_q < RUN_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCK: begin
        if (cnt_q >= LOCK_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered drive matches the state it enters.
  always_comb begin
    heat_d    = (state_d == ST_RUN) && (mode_d == MODE_HEAT);
    cool_d    = (state_d == ST_RUN) && (mode_d == MODE_COOL);
    idle_d    = ~(heat_d | cool_d);
    lockout_d = (state_d == ST_LOCK);
    grant_d   = (state_d == ST_RUN) ? (ONE_HOT0 << gid_d) : '0;
  end

  assign heat        = heat_q;
  assign cool        = cool_q;
  assign idle        = idle_q;
  assign lockout     = lockout_q;
  assign zone_grant  = grant_q;
  assign grant_id    = gid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Bench for hvac_zone_scheduler: directed scenarios plus randomized traffic against a timing model.
module tb_hvac_zone_scheduler;
  import hvac_pkg::*;

  localparam int N    = 4;
  localparam int MIN  = 16;
  localparam int MAX  = 64;
  localparam int LOCK = 8;
  localparam int IW   = $clog2(N);
  localparam int W    = 4 + N + IW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] heat_req = '0;
  logic [N-1:0] cool_req = '0;
  logic heat, cool, idle, lockout;
  logic [N-1:0] zone_grant;
  logic [IW-1:0] grant_id;
  state_t dbg_state;

  always #5 clk = ~clk;

  hvac_zone_scheduler #(
    .N_ZONES(N), .MIN_RUN_CYC(MIN), .MAX_RUN_CYC(MAX), .LOCKOUT_CYC(LOCK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .heat_req    (heat_req),
    .cool_req    (cool_req),
    .heat        (heat),
    .cool        (cool),
    .idle        (idle),
    .lockout     (lockout),
    .zone_grant  (zone_grant),
    .grant_id    (grant_id),
    .dbg_state_o (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks how long the plant has been on and how many off cycles remain.
  int m_run = 0, m_heat = 0, m_zone = 0, m_id = 0, m_last = N - 1, m_on = 0, m_lock = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or posedge reset) begin : model
    int still, others, z;
    logic [N-1:0] gvec;
    logic [N-1:0] one;
    if (reset) begin
      m_run = 0; m_heat = 0; m_zone = 0; m_id = 0; m_last = N - 1; m_on = 0; m_lock = 0;
    end else if (m_run != 0) begin
      if (m_heat != 0) still = int'(heat_req[m_zone] && !cool_req[m_zone]);
      else             still = int'(cool_req[m_zone] && !heat_req[m_zone]);
      others = 0;
      for (int i = 0; i < N; i++)
        if (i != m_zone && (heat_req[i] ^ cool_req[i])) others = 1;
      if ((m_on >= MIN && still == 0) || (m_on >= MAX && others != 0)) begin
        m_run = 0;
        m_lock = LOCK;
      end else begin
        m_on++;
      end
    end else if (m_lock > 0) begin
      m_lock--;
    end else begin
      for (int k = 1; k <= N; k++) begin
        z = (m_last + k) % N;
        if (m_run == 0 && (heat_req[z] ^ cool_req[z])) begin
          m_run = 1; m_on = 1; m_zone = z; m_id = z; m_last = z;
          m_heat = int'(heat_req[z]);
        end
      end
    end
    one  = 1;
    gvec = (m_run != 0) ? (one << m_zone) : '0;
    exp_q.push_back({(m_run != 0 && m_heat != 0), (m_run != 0 && m_heat == 0), (m_run == 0),
                     (m_lock > 0), gvec, IW'(m_id)});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    logic [W-1:0] ev;
    if (exp_q.size() > 0) begin
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      ev = exp_q.pop_front();
      chk("heat",       int'(heat),       int'(ev[W-1]));
      chk("cool",       int'(cool),       int'(ev[W-2]));
      chk("idle",       int'(idle),       int'(ev[W-3]));
      chk("lockout",    int'(lockout),    int'(ev[W-4]));
      chk("zone_grant", int'(zone_grant), int'(ev[IW+N-1:IW]));
      chk("grant_id",   int'(grant_id),   int'(ev[IW-1:0]));
      chk("inv_heat_and_cool", int'(heat & cool), 0);
      chk("inv_onehot",        int'($onehot0(zone_grant)), 1);
      chk("inv_idle",          int'(idle), int'(!(heat | cool)));
      chk("inv_grant_iff_run", int'(zone_grant != '0), int'(dbg_state == ST_RUN));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    #1 reset = 1'b1;
    heat_req = '0;
    cool_req = '0;
    repeat (cycles) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  int run_len[8], run_id[8], run_gap[8], run_cool[8];
  int run_starts, run_done;

  // Samples drive edges; optionally clears all heat requests after drop_at cycles of the first run.
  task automatic measure_runs(input int nstarts, input int budget, input int drop_at);
    int cur, gap;
    bit prev, d;
    run_starts = 0; run_done = 0; cur = 0; gap = 0; prev = 1'b0;
    for (int c = 0; c < budget && run_starts < nstarts; c++) begin
      @(negedge clk);
      d = heat | cool;
      if (d) begin
        if (!prev) begin
          if (run_starts > 0) run_gap[run_starts-1] = gap;
          run_id[run_starts]   = int'(grant_id);
          run_cool[run_starts] = int'(cool);
          run_starts++;
          cur = 0;
        end
        cur++;
        if (drop_at > 0 && run_starts == 1 && cur == drop_at) begin
          #1 heat_req = '0;
        end
      end else if (prev) begin
        run_len[run_done] = cur;
        run_done++;
        gap = 1;
      end else begin
        gap++;
      end
      prev = d;
    end
    chk("measure_budget", run_starts, nstarts);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int quiet_bad, hc, lc, gbad, ndrive, hold;

    // Reset held, then a long quiet stretch.
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    quiet_bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (heat || cool || !idle || lockout || zone_grant != '0 || grant_id != '0) quiet_bad++;
    end
    chk("t1_quiet_cycles", quiet_bad, 0);
    chk("t1_idle", int'(idle), 1);

    // Short heating request still gets the full minimum on-time.
    #1 heat_req[2] = 1'b1;
    hc = 0; lc = 0; gbad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (heat) begin
        hc++;
        if (zone_grant != 4'b0100) gbad++;
      end
      if (lockout) lc++;
      if (c == 4) #1 heat_req[2] = 1'b0;
    end
    chk("t2_heat_cycles", hc, 16);
    chk("t2_lock_cycles", lc, 8);
    chk("t2_grant_bad", gbad, 0);
    chk("t2_idle_after", int'(idle), 1);
    chk("t2_grant_id", int'(grant_id), 2);

    // Two competing coolers alternate at the quantum.
    do_reset(3);
    cool_req = 4'b1001;
    measure_runs(4, 500, 0);
    chk("t3_len0", run_len[0], 64);
    chk("t3_len1", run_len[1], 64);
    chk("t3_len2", run_len[2], 64);
    chk("t3_id0", run_id[0], 0);
    chk("t3_id1", run_id[1], 3);
    chk("t3_id2", run_id[2], 0);
    chk("t3_id3", run_id[3], 3);
    chk("t3_gap0", run_gap[0], 9);
    chk("t3_gap1", run_gap[1], 9);
    chk("t3_cool0", run_cool[0], 1);

    // Conflicting request is ignored; a valid one still gets served.
    do_reset(3);
    heat_req = 4'b0010;
    cool_req = 4'b0010;
    ndrive = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (heat || cool || zone_grant != '0) ndrive++;
    end
    chk("t4_no_grant", ndrive, 0);
    #1 cool_req = 4'b0110;
    measure_runs(1, 10, 0);
    chk("t4_id", run_id[0], 2);
    chk("t4_cool", run_cool[0], 1);
    gbad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (zone_grant != 4'b0100 || !cool) gbad++;
    end
    chk("t4_held_grant", gbad, 0);

    // Asynchronous reset in the middle of a run.
    do_reset(3);
    heat_req = 4'b0001;
    measure_runs(1, 10, 0);
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_heat", int'(heat), 0);
    chk("t5_async_grant", int'(zone_grant), 0);
    chk("t5_async_idle", int'(idle), 1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_regrant_heat", int'(heat), 1);
    chk("t5_regrant_grant", int'(zone_grant), 1);
    chk("t5_no_lockout", int'(lockout), 0);

    // Early drop holds to minimum on-time, then the waiting zone is served.
    do_reset(3);
    heat_req = 4'b0010;
    cool_req = 4'b0100;
    measure_runs(2, 100, 3);
    chk("t6_id0", run_id[0], 1);
    chk("t6_cool0", run_cool[0], 0);
    chk("t6_len0", run_len[0], 16);
    chk("t6_gap0", run_gap[0], 9);
    chk("t6_id1", run_id[1], 2);
    chk("t6_cool1", run_cool[1], 1);

    // Randomized traffic with occasional asynchronous resets.
    do_reset(2);
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      if (hold == 0) begin
        heat_req = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        cool_req = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        hold = $urandom_range(5, 150);
      end else begin
        hold--;
      end
      if (!reset && $urandom_range(0, 499) == 0) reset = 1'b1;
      else if (reset && $urandom_range(0, 2) == 0) reset = 1'b0;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
